// File: rtl/cim_pkg.sv
// -----------------------------------------------------------------------------
// cim_pkg
// Shared constants and helpers for the CIM weight-loading path.
//   CIM_ROWS   : rows per bank (width of the WA0/WA1 strobes)
//   CIM_DW     : weight word width (width of D)
//   CIM_HALF_W : width of one readback half-word (D is split low/high)
//   ST_*       : loader FSM state codes
//   row_onehot : one-hot write strobe for a row index
// -----------------------------------------------------------------------------
package cim_pkg;

    localparam int CIM_ROWS   = 8;
    localparam int CIM_DW     = 24;
    localparam int CIM_HALF_W = 12;
    localparam int CIM_ROW_W  = 3;

    typedef logic [2:0] ld_state_t;

    localparam ld_state_t ST_IDLE   = 3'd0;
    localparam ld_state_t ST_ACCEPT = 3'd1;
    localparam ld_state_t ST_SETUP  = 3'd2;
    localparam ld_state_t ST_PULSE  = 3'd3;
    localparam ld_state_t ST_HOLD   = 3'd4;
    localparam ld_state_t ST_CHECK  = 3'd5;

    function automatic logic [CIM_ROWS-1:0] row_onehot(input logic [CIM_ROW_W-1:0] row);
        logic [CIM_ROWS-1:0] oh;
        oh      = {CIM_ROWS{1'b0}};
        oh[row] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/cim_wr_timer.sv
// -----------------------------------------------------------------------------
// cim_wr_timer
// Loadable down-counter used to time the SETUP / PULSE / HOLD phases.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   load     : load load_val into the counter this cycle
//   load_val : phase length minus one
//   zero     : counter is at zero (current phase ends this cycle)
// The counter saturates at zero so an idle timer stays quiet.
// -----------------------------------------------------------------------------
module cim_wr_timer #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          zero
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: load wins, otherwise count down and stop at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != {CW{1'b0}}) begin
            cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == {CW{1'b0}});

endmodule

// File: rtl/cim_weight_loader.sv
// -----------------------------------------------------------------------------
// cim_weight_loader
// Write sequencer in front of cim_array: takes a valid/ready stream of weight
// words and writes them to rows 0..ROWS-1 of one bank, with D held stable for
// a setup phase, a one-hot WA strobe phase and a hold phase per row.
//
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   start, start_bank : begin a bank fill (sampled only when idle)
//   in_valid/in_ready : weight word handshake, in_data carries the word
//   busy              : fill in progress
//   done              : one-cycle pulse after the last row's hold
//   D, WA0, WA1       : cim_array write data and per-bank row strobes
// Optional (macro CIM_LOADER_READBACK_EN):
//   rb_wb0_a/_b, rb_wb1_a/_b : array readback (stored data inverted)
//   err                      : sticky readback mismatch flag
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module cim_weight_loader
    import cim_pkg::*;
#(
    parameter int ROWS      = CIM_ROWS,
    parameter int DW        = CIM_DW,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 1,
    parameter int HOLD_CYC  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   start_bank,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DW-1:0]          in_data,
    output logic                   busy,
    output logic                   done,
`ifdef CIM_LOADER_READBACK_EN
    input  logic [ROWS*DW/2-1:0]   rb_wb0_a,
    input  logic [ROWS*DW/2-1:0]   rb_wb0_b,
    input  logic [ROWS*DW/2-1:0]   rb_wb1_a,
    input  logic [ROWS*DW/2-1:0]   rb_wb1_b,
    output logic                   err,
`endif
    output logic [DW-1:0]          D,
    output logic [ROWS-1:0]        WA0,
    output logic [ROWS-1:0]        WA1
);

    localparam int                ROW_W    = $clog2(ROWS);
    localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [7:0]        SETUP_LD = 8'(SETUP_CYC - 1);
    localparam logic [7:0]        PULSE_LD = 8'(PULSE_CYC - 1);
    localparam logic [7:0]        HOLD_LD  = 8'(HOLD_CYC - 1);

    ld_state_t        state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             bank_q, bank_d;
    logic [DW-1:0]    d_q, d_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             in_ready_q, in_ready_d;
    logic [ROWS-1:0]  wa0_q, wa0_d;
    logic [ROWS-1:0]  wa1_q, wa1_d;
    logic [ROWS-1:0]  strobe_s;

    logic             tmr_load_s;
    logic [7:0]       tmr_val_s;
    logic             tmr_zero_s;

`ifdef CIM_LOADER_READBACK_EN
    logic             err_q, err_d;
    logic             rb_bad_s;
    logic [ROWS*DW/2-1:0] rb_a_s;
    logic [ROWS*DW/2-1:0] rb_b_s;
    int               rb_lsb_s;

    // Readback compare for the row just written: array returns ~data.
    always_comb begin
        if (bank_q) begin
            rb_a_s = rb_wb1_a;
            rb_b_s = rb_wb1_b;
        end else begin
            rb_a_s = rb_wb0_a;
            rb_b_s = rb_wb0_b;
        end
        rb_lsb_s = int'(row_q) * CIM_HALF_W;
        rb_bad_s = (rb_a_s[rb_lsb_s +: CIM_HALF_W] != ~d_q[CIM_HALF_W-1:0]) ||
                   (rb_b_s[rb_lsb_s +: CIM_HALF_W] != ~d_q[DW-1:CIM_HALF_W]);
    end
`endif

    cim_wr_timer #(.CW(8)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .zero     (tmr_zero_s)
    );

    // Main FSM: phase sequencing, row/bank bookkeeping and data capture.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        bank_d     = bank_q;
        d_d        = d_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        tmr_load_s = 1'b0;
        tmr_val_s  = 8'd0;
`ifdef CIM_LOADER_READBACK_EN
        err_d      = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bank_d  = start_bank;
                    row_d   = {ROW_W{1'b0}};
                    busy_d  = 1'b1;
                    state_d = ST_ACCEPT;
`ifdef CIM_LOADER_READBACK_EN
                    err_d   = 1'b0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCEPT: begin
                if (in_valid && in_ready_q) begin
                    d_d        = in_data;
                    state_d    = ST_SETUP;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = SETUP_LD;
                end else begin
                    state_d = ST_ACCEPT;
                end
            end
            ST_SETUP: begin
                if (tmr_zero_s) begin
                    state_d    = ST_PULSE;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = PULSE_LD;
                end else begin
                    state_d = ST_SETUP;
                end
            end
            ST_PULSE: begin
                if (tmr_zero_s) begin
                    state_d    = ST_HOLD;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = HOLD_LD;
                end else begin
                    state_d = ST_PULSE;
                end
            end
            ST_HOLD: begin
                if (tmr_zero_s) begin
`ifdef CIM_LOADER_READBACK_EN
                    state_d = ST_CHECK;
`else
                    if (row_q == LAST_ROW) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        row_d   = row_q + {{(ROW_W-1){1'b0}}, 1'b1};
                        state_d = ST_ACCEPT;
                    end
`endif
                end else begin
                    state_d = ST_HOLD;
                end
            end
`ifdef CIM_LOADER_READBACK_EN
            ST_CHECK: begin
                if (rb_bad_s) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
                if (row_q == LAST_ROW) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    row_d   = row_q + {{(ROW_W-1){1'b0}}, 1'b1};
                    state_d = ST_ACCEPT;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Registered outputs are decoded from the next state so they line up
    // with the state they belong to.
    always_comb begin
        in_ready_d = (state_d == ST_ACCEPT);
        strobe_s   = row_onehot(row_d);
        if (state_d == ST_PULSE) begin
            if (bank_d) begin
                wa0_d = {ROWS{1'b0}};
                wa1_d = strobe_s;
            end else begin
                wa0_d = strobe_s;
                wa1_d = {ROWS{1'b0}};
            end
        end else begin
            wa0_d = {ROWS{1'b0}};
            wa1_d = {ROWS{1'b0}};
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            row_q      <= {ROW_W{1'b0}};
            bank_q     <= 1'b0;
            d_q        <= {DW{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b0;
            wa0_q      <= {ROWS{1'b0}};
            wa1_q      <= {ROWS{1'b0}};
`ifdef CIM_LOADER_READBACK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            bank_q     <= bank_d;
            d_q        <= d_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            in_ready_q <= in_ready_d;
            wa0_q      <= wa0_d;
            wa1_q      <= wa1_d;
`ifdef CIM_LOADER_READBACK_EN
            err_q      <= err_d;
`endif
        end
    end

    assign D        = d_q;
    assign WA0      = wa0_q;
    assign WA1      = wa1_q;
    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
`ifdef CIM_LOADER_READBACK_EN
    assign err      = err_q;
`endif

endmodule

// File: tb/tb_cim_weight_loader.sv
// -----------------------------------------------------------------------------
// tb_cim_weight_loader
// Self-checking bench for cim_weight_loader (default build). The reference
// model is a queue of expected row writes: the k-th word accepted after a
// start belongs to row k of the started bank. A monitor pops one entry per
// observed strobe and checks bank, row, data and the D setup/hold window.
// -----------------------------------------------------------------------------
module tb_cim_weight_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        start_bank;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_data;
    logic        busy;
    logic        done;
    logic [23:0] D;
    logic [7:0]  WA0;
    logic [7:0]  WA1;

    cim_weight_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_bank (start_bank),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .busy       (busy),
        .done       (done),
        .D          (D),
        .WA0        (WA0),
        .WA1        (WA1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        bank;
        int          row;
        logic [23:0] data;
    } wr_t;

    wr_t   exp_q[$];
    logic  m_bank;
    int    m_row;
    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc = 0;
    int    done_cnt = 0;
    int    first_hs = -1;
    bit    tog = 1'b0;

    logic        post_v = 1'b0;
    logic [23:0] post_d;
    logic [23:0] prev_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: invariants, strobe order/data, D setup and hold.
    always @(negedge clk) begin
        wr_t        e;
        logic [7:0] one;
        logic [7:0] expw;
        if (rst) begin
            post_v = 1'b0;
        end else begin
            chk("wa_exclusive", {31'd0, (WA0 != 8'd0) && (WA1 != 8'd0)}, 32'd0);
            chk("wa0_onehot0", {31'd0, $onehot0(WA0)}, 32'd1);
            chk("wa1_onehot0", {31'd0, $onehot0(WA1)}, 32'd1);
            if (post_v) begin
                chk("hold_d", {8'd0, D}, {8'd0, post_d});
                chk("hold_wa_low", {24'd0, WA0 | WA1}, 32'd0);
                post_v = 1'b0;
            end
            if ((WA0 != 8'd0) || (WA1 != 8'd0)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    e    = exp_q.pop_front();
                    one  = 8'd1;
                    expw = one << e.row;
                    chk("wa0_strobe", {24'd0, WA0}, {24'd0, (e.bank ? 8'd0 : expw)});
                    chk("wa1_strobe", {24'd0, WA1}, {24'd0, (e.bank ? expw : 8'd0)});
                    chk("strobe_d", {8'd0, D}, {8'd0, e.data});
                    chk("setup_d", {8'd0, prev_d}, {8'd0, e.data});
                    post_v = 1'b1;
                    post_d = e.data;
                end
            end
            if (done) done_cnt++;
        end
        prev_d = D;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_fill(input logic bank);
        start      = 1'b1;
        start_bank = bank;
        m_bank     = bank;
        m_row      = 0;
        first_hs   = -1;
        step();
        start      = 1'b0;
        start_bank = ~bank;   // later changes must have no effect
        @(negedge clk);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("ready_after_start", {31'd0, in_ready}, 32'd1);
        step();
    endtask

    // mode 0: valid always high, 1: toggle every cycle, 2: random
    task automatic feed(input logic [23:0] w, input int mode);
        bit acc = 1'b0;
        wr_t e;
        for (int n = 0; n < 200 && !acc; n++) begin
            case (mode)
                0:       in_valid = 1'b1;
                1:       begin in_valid = tog; tog = ~tog; end
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = w;
            @(negedge clk);
            if (in_valid && in_ready) begin
                acc    = 1'b1;
                e.bank = m_bank;
                e.row  = m_row;
                e.data = w;
                exp_q.push_back(e);
                if (first_hs < 0) first_hs = cyc;
                m_row++;
            end
            step();
        end
        in_valid = 1'b0;
        if (!acc) chk("feed_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(output int at);
        at = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                at = cyc;
                chk("busy_at_done", {31'd0, busy}, 32'd0);
                break;
            end
        end
        if (at < 0) chk("done_timeout", 32'd0, 32'd1);
        step();
        step();
        chk("all_rows_written", exp_q.size(), 32'd0);
    endtask

    task automatic fill(input logic bank, input int mode, input logic [23:0] base, input bit rnd);
        int d0;
        int at;
        d0 = done_cnt;
        start_fill(bank);
        for (int k = 0; k < 8; k++)
            feed(rnd ? 24'($urandom) : base + 24'(k), mode);
        wait_done(at);
        chk("one_done", done_cnt - d0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int at;
        int d0;
        rst        = 1'b1;
        start      = 1'b0;
        start_bank = 1'b0;
        in_valid   = 1'b1;
        in_data    = 24'h123456;

        // Reset held for two cycles with in_valid high.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_d", {8'd0, D}, 32'd0);
            chk("rst_wa", {16'd0, WA0, WA1}, 32'd0);
            chk("rst_ready", {31'd0, in_ready}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_done", {31'd0, done}, 32'd0);
        end
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        step();
        step();
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Bank 0, in_valid always high, latency check on done.
        d0 = done_cnt;
        start_fill(1'b0);
        for (int k = 0; k < 8; k++) feed(24'hA00 + 24'(k), 0);
        wait_done(at);
        chk("done_latency", at - first_hs, 32'd32);
        chk("bank0_one_done", done_cnt - d0, 32'd1);

        // Bank 1 with in_valid toggling.
        tog = 1'b1;
        fill(1'b1, 1, 24'hB00, 1'b0);

        // Start pulsed during the third word's strobe must be ignored.
        d0 = done_cnt;
        start_fill(1'b0);
        fork
            begin
                for (int k = 0; k < 8; k++) feed(24'($urandom), 2);
            end
            begin
                bit seen = 1'b0;
                for (int i = 0; i < 300 && !seen; i++) begin
                    @(negedge clk);
                    if (WA0 == 8'h04) seen = 1'b1;
                end
                chk("saw_row2_strobe", {31'd0, seen}, 32'd1);
                start      = 1'b1;
                start_bank = 1'b1;
                step();
                start      = 1'b0;
            end
        join
        wait_done(at);
        chk("busy_start_one_done", done_cnt - d0, 32'd1);

        // Reset during row 3's strobe.
        d0 = done_cnt;
        start_fill(1'b1);
        for (int k = 0; k < 4; k++) feed(24'hC00 + 24'(k), 0);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (WA1 == 8'h08) seen = 1'b1;
            end
            chk("saw_row3_strobe", {31'd0, seen}, 32'd1);
        end
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("midrst_wa1", {24'd0, WA1}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_d", {8'd0, D}, 32'd0);
        step();
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 10; i++) step();
        chk("midrst_no_done", done_cnt - d0, 32'd0);
        chk("midrst_idle_busy", {31'd0, busy}, 32'd0);

        // New fill after reset starts from row 0; then random fills.
        fill(1'b1, 0, 24'hD00, 1'b0);
        for (int r = 0; r < 3; r++) fill(1'($urandom_range(0, 1)), 2, 24'd0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
